// File: rtl/ui_pkg.sv
// ui_pkg -- shared front-panel constants.
//   Default timing for the push-button front end (50 MHz system clock),
//   idle levels for the board KEY/SW inputs, and the key FSM state type.
//   No ports; imported by the front-panel modules.
package ui_pkg;

  // Default key timing at 50 MHz.
  localparam int unsigned KEY_DEBOUNCE_CYCLES_DEF = 500000;   // 10 ms
  localparam int unsigned KEY_LONG_CYCLES_DEF     = 50000000; // 1 s

  // Idle/reset levels of the raw board inputs.
  localparam logic KEY_RELEASED_LVL = 1'b1;  // KEY buttons are active-low
  localparam logic SW_RESET_LVL     = 1'b0;  // slide switches park low

  // Number of board push-buttons and slide switches.
  localparam int unsigned UI_NUM_KEYS = 4;
  localparam int unsigned UI_NUM_SW   = 10;

  // Key debounce/pulse FSM states (fixed 2-bit encoding).
  typedef enum logic [1:0] {
    KEY_IDLE         = 2'd0,
    KEY_PRESS_WAIT   = 2'd1,
    KEY_PRESSED      = 2'd2,
    KEY_RELEASE_WAIT = 2'd3
  } key_state_e;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff -- two-flop synchronizer for asynchronous board inputs.
//   Parameters: WIDTH   - number of independent bits synchronized
//               RST_VAL - value both flop stages take during reset
//   Ports:      clk    - destination clock
//               rst_n  - asynchronous active-low reset
//               d_i    - asynchronous input bits
//               q_o    - synchronized bits (two clk edges of latency)
module sync_2ff #(
  parameter int unsigned       WIDTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_pulse_gen.sv
// key_pulse_gen -- push-button debouncer and event pulse generator.
//   Parameters: DEBOUNCE_CYCLES - consecutive stable synchronized samples
//                                 needed to accept a level change
//               LONG_CYCLES     - cycles a debounced press must be held,
//                                 counted from press_p, before long_p fires
//   Ports:      clk       - system clock
//               rst_n     - asynchronous active-low reset
//               key_n     - raw active-low bouncing push-button
//               key_level - debounced pressed state (1 = pressed)
//               press_p   - one-cycle pulse on each accepted press
//               release_p - one-cycle pulse on each accepted release
//               long_p    - one-cycle pulse once per press held LONG_CYCLES
module key_pulse_gen
  import ui_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES     = KEY_LONG_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_level,
  output logic press_p,
  output logic release_p,
  output logic long_p
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned HW = $clog2(LONG_CYCLES) + 1;

  localparam logic [DW-1:0] DEB_ONE   = DW'(1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  // With a single-sample debounce the first differing sample is already
  // the accepting one, so the wait states are bypassed.
  localparam bit SINGLE_SAMPLE = (DEBOUNCE_CYCLES <= 1);

  // ---------------------------------------------------------------------
  // Input synchronizer (resets to the released level)
  // ---------------------------------------------------------------------
  logic key_sync_n;
  logic key_s;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (KEY_RELEASED_LVL)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (key_n),
    .q_o   (key_sync_n)
  );

  assign key_s = ~key_sync_n;

  // ---------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------
  key_state_e      state_q,   state_d;
  logic [DW-1:0]   deb_q,     deb_d;
  logic [HW-1:0]   hold_q,    hold_d;
  logic            level_q,   level_d;
  logic            press_q,   press_d;
  logic            release_q, release_d;
  logic            long_q,    long_d;
  logic [HW-1:0]   hold_inc;

  assign hold_inc = hold_q + HOLD_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= KEY_IDLE;
      deb_q     <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      deb_q     <= deb_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    deb_d     = deb_q;
    hold_d    = hold_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;

    unique case (state_q)
      KEY_IDLE: begin
        if (key_s) begin
          if (SINGLE_SAMPLE) begin
            state_d = KEY_PRESSED;
            press_d = 1'b1;
            level_d = 1'b1;
            hold_d  = '0;
          end else begin
            state_d = KEY_PRESS_WAIT;
            deb_d   = DEB_ONE;
          end
        end
      end

      KEY_PRESS_WAIT: begin
        if (!key_s) begin
          // bounce: drop back without any pulse
          state_d = KEY_IDLE;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = KEY_PRESSED;
          press_d = 1'b1;
          level_d = 1'b1;
          deb_d   = '0;
          hold_d  = '0;
        end else begin
          deb_d = deb_q + DEB_ONE;
        end
      end

      KEY_PRESSED: begin
        if (!key_s) begin
          if (SINGLE_SAMPLE) begin
            state_d   = KEY_IDLE;
            release_d = 1'b1;
            level_d   = 1'b0;
          end else begin
            state_d = KEY_RELEASE_WAIT;
            deb_d   = DEB_ONE;
          end
        end else if (hold_q < HOLD_LAST) begin
          // hold counter saturates at LONG_CYCLES-1, so long_p fires once
          hold_d = hold_inc;
          long_d = (hold_inc == HOLD_LAST);
        end
      end

      KEY_RELEASE_WAIT: begin
        if (key_s) begin
          // bounce: resume the press; hold count continues from where it froze
          state_d = KEY_PRESSED;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d   = KEY_IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
          deb_d     = '0;
        end else begin
          deb_d = deb_q + DEB_ONE;
        end
      end

      default: begin
        state_d = KEY_IDLE;
        deb_d   = '0;
        hold_d  = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign key_level = level_q;
  assign press_p   = press_q;
  assign release_p = release_q;
  assign long_p    = long_q;

endmodule

// File: tb/tb_key_pulse_gen.sv
// tb_key_pulse_gen -- self-checking bench for key_pulse_gen with
//   DEBOUNCE_CYCLES=4, LONG_CYCLES=10. Directed scenarios plus random
//   key activity, all compared against a behavioural reference model.
module tb_key_pulse_gen;

  localparam int unsigned D = 4;
  localparam int unsigned L = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic key_n = 1'b1;
  logic key_level, press_p, release_p, long_p;

  key_pulse_gen #(
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_n     (key_n),
    .key_level (key_level),
    .press_p   (press_p),
    .release_p (release_p),
    .long_p    (long_p)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: key_n delayed two samples; a level change is accepted
  // once D consecutive samples disagree with the current level; held time
  // counts only cycles where the key is settled pressed.
  bit m_s1, m_s2, m_level, e_press, e_rel, e_long;
  int m_run, m_held;

  // Event statistics per scenario (cycle numbers relative to clr_stats)
  int cyc, press_cnt, rel_cnt, long_cnt, press_cyc, rel_cyc, long_cyc;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1'b1; m_s2 = 1'b1;
    m_level = 1'b0; m_run = 0; m_held = 0;
    e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
  endtask

  task automatic model_edge();
    bit ks;
    ks = ~m_s2;
    m_s2 = m_s1;
    m_s1 = key_n;
    e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
    if (ks != m_level) begin
      m_run++;
      if (m_run >= int'(D)) begin
        m_level = ks;
        m_run   = 0;
        if (ks) begin
          e_press = 1'b1;
          m_held  = 0;
        end else begin
          e_rel = 1'b1;
        end
      end
    end else begin
      // a settled pressed cycle (not the one ending a rejected release bounce)
      if (m_level && m_run == 0 && m_held < int'(L) - 1) begin
        m_held++;
        if (m_held == int'(L) - 1) e_long = 1'b1;
      end
      m_run = 0;
    end
  endtask

  task automatic check_outs(input string tag);
    chk_bit({tag, ".key_level"}, key_level, m_level);
    chk_bit({tag, ".press_p"},   press_p,   e_press);
    chk_bit({tag, ".release_p"}, release_p, e_rel);
    chk_bit({tag, ".long_p"},    long_p,    e_long);
  endtask

  task automatic clr_stats();
    cyc = 0; press_cnt = 0; rel_cnt = 0; long_cnt = 0;
    press_cyc = -1; rel_cyc = -1; long_cyc = -1;
  endtask

  // One clock: drive inputs on the falling edge, update the model on the
  // rising edge, compare 1 time unit later.
  task automatic step(input logic kn, input logic rn, input string tag);
    @(negedge clk);
    key_n = kn;
    rst_n = rn;
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge();
    #1;
    cyc++;
    if (press_p)   begin press_cnt++; if (press_cyc < 0) press_cyc = cyc; end
    if (release_p) begin rel_cnt++;   if (rel_cyc   < 0) rel_cyc   = cyc; end
    if (long_p)    begin long_cnt++;  if (long_cyc  < 0) long_cyc  = cyc; end
    check_outs(tag);
    chk_bit({tag, ".excl"}, $onehot0({press_p, release_p, long_p}), 1'b1);
  endtask

  task automatic run(input logic kn, input int n, input string tag);
    repeat (n) step(kn, 1'b1, tag);
  endtask

  initial begin
    int kn, len;
    model_reset();
    clr_stats();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset");

    // Clean press held 20 cycles: press at 6, long at 15 only
    clr_stats();
    run(1'b0, 20, "clean");
    chk_int("clean.press_cyc", press_cyc, 6);
    chk_int("clean.press_cnt", press_cnt, 1);
    chk_int("clean.long_cyc",  long_cyc, 15);
    chk_int("clean.long_cnt",  long_cnt, 1);
    clr_stats();
    run(1'b1, 10, "clean_rel");
    chk_int("clean_rel.rel_cyc", rel_cyc, 6);
    chk_int("clean_rel.rel_cnt", rel_cnt, 1);

    // Press bounce: 3 low, 1 high, 3 low, then high
    clr_stats();
    run(1'b0, 3, "bounce");
    run(1'b1, 1, "bounce");
    run(1'b0, 3, "bounce");
    run(1'b1, 10, "bounce");
    chk_int("bounce.press_cnt", press_cnt, 0);
    chk_bit("bounce.level", key_level, 1'b0);

    // Short press: 8 cycles then clean release
    clr_stats();
    run(1'b0, 8, "short");
    chk_int("short.press_cnt", press_cnt, 1);
    clr_stats();
    run(1'b1, 10, "short_rel");
    chk_int("short_rel.rel_cyc",  rel_cyc, 6);
    chk_int("short_rel.long_cnt", long_cnt, 0);

    // Release bounce: hold time freezes during the rejected release
    clr_stats();
    run(1'b0, 10, "relbounce");
    run(1'b1, 2,  "relbounce");
    run(1'b0, 12, "relbounce");
    chk_int("relbounce.rel_cnt",  rel_cnt, 0);
    chk_int("relbounce.long_cyc", long_cyc, 18);
    chk_bit("relbounce.level", key_level, 1'b1);
    run(1'b1, 10, "relbounce_rel");

    // Reset mid-press
    clr_stats();
    run(1'b0, 8, "rstmid");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outs("rstmid.async");
    step(1'b0, 1'b0, "rstmid.held");
    step(1'b0, 1'b0, "rstmid.held");
    clr_stats();
    run(1'b0, 10, "rstmid.after");
    chk_int("rstmid.press_cyc", press_cyc, 6);
    chk_int("rstmid.rel_cnt",   rel_cnt, 0);
    run(1'b1, 10, "rstmid_rel");

    // Random key activity with occasional resets
    for (int b = 0; b < 200; b++) begin
      kn  = int'($urandom_range(0, 1));
      len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(12, 30))
                                         : int'($urandom_range(1, 7));
      if ($urandom_range(0, 49) == 0) step(kn[0], 1'b0, "rand.rst");
      run(kn[0], len, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/key_pulse_gen.md
KEY_PULSE_GEN -- requirements
Module: key_pulse_gen

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable synchronized samples required to accept a level change (10 ms at 50 MHz).
REQ-002 SHALL have parameter LONG_CYCLES, default 50000000, meaning cycles a debounced press must be held before long_p fires (1 s at 50 MHz).
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic is in this domain.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port key_n, input, 1, raw board push-button, active-low, asynchronous, bouncing.
REQ-006 SHALL have port key_level, output, 1, debounced pressed state (1 = pressed).
REQ-007 SHALL have port press_p, output, 1, one-cycle pulse on each accepted press; drives sel_p of the TIME/DATE selector.
REQ-008 SHALL have port release_p, output, 1, one-cycle pulse on each accepted release.
REQ-009 SHALL have port long_p, output, 1, one-cycle pulse once per press held LONG_CYCLES after press_p.

Function
REQ-010 SHALL pass key_n through a 2-flop synchronizer, inverted to an active-high sample key_s; no other logic SHALL read key_n.
REQ-011 SHALL implement FSM states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-012 IDLE: key_s=1 -> PRESS_WAIT, counter cleared to 1; otherwise stay.
REQ-013 PRESS_WAIT: key_s=0 -> IDLE (bounce rejected, no pulse); key_s=1 with counter=DEBOUNCE_CYCLES-1 -> PRESSED; else counter+1.
REQ-014 PRESS_WAIT->PRESSED transition SHALL register press_p=1 and key_level=1 on the same edge; press_p high exactly one cycle.
REQ-015 Latency key_n fall (clean) to press_p high SHALL be exactly DEBOUNCE_CYCLES+2 clk edges.
REQ-016 PRESSED: hold counter SHALL count cycles from press_p; at count LONG_CYCLES-1 SHALL pulse long_p one cycle, then saturate (no further long_p this press).
REQ-017 PRESSED: key_s=0 -> RELEASE_WAIT, debounce counter cleared to 1; hold counter freezes.
REQ-018 RELEASE_WAIT: key_s=1 -> PRESSED (bounce rejected, hold counter resumes, no pulse); key_s=0 with counter=DEBOUNCE_CYCLES-1 -> IDLE, registering release_p=1, key_level=0.
REQ-019 Counters SHALL be $clog2 of their parameter +1 bits wide and never wrap; long_p SHALL never fire for a press released before LONG_CYCLES.
REQ-020 press_p, release_p, long_p SHALL be registered and mutually exclusive in any cycle.
REQ-021 DEBOUNCE_CYCLES=1 SHALL be legal: accept a change after one stable sample.

Reset
REQ-022 rst_n low SHALL asynchronously force state IDLE, both counters 0, synchronizer flops to "released", key_level=0, press_p=0, release_p=0, long_p=0.
REQ-023 Reset asserted mid-press SHALL produce no release_p; after deassertion a still-held key SHALL be re-debounced and yield a fresh press_p.
REQ-024 First edge after rst_n rises SHALL not generate any pulse.

Structure
REQ-025 State encodings (2-bit localparams) and default timing parameters SHALL live in the shared ui_pkg include alongside other front-panel constants.
REQ-026 The synchronizer SHALL be a separate sub-module sync_2ff (parameterized reset value), reused for all KEY/SW inputs.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=10)
REQ-027 Clean press: key_n 1->0 at cycle 0, held -> press_p high only at cycle 6, key_level=1 from cycle 6.
REQ-028 Bounce: key_n low 3 cycles, high 1, low 3, high -> no press_p, key_level stays 0, state returns IDLE.
REQ-029 Long hold: clean press held 20 cycles -> press_p at cycle 6, long_p at cycle 15 only, no second long_p.
REQ-030 Short press: press held 8 cycles then released clean -> press_p once, release_p 6 cycles after key_n rise, no long_p.
REQ-031 Release bounce: while PRESSED, key_n high 2 cycles then low -> no release_p, key_level stays 1.
REQ-032 Reset mid-press: rst_n low 2 cycles during PRESSED with key held -> outputs 0 immediately, fresh press_p 6 cycles after rst_n rises, no release_p.
